// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per clock.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int W2    = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] a_orig_q, a_orig_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dz_q, dz_d;

  logic             signed_op;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_step;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             q_bit;
  logic [W2-1:0]    div_step;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] fin_hi, fin_lo;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? WIDTH'(-v) : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [W2-1:0] neg_w2(input logic [W2-1:0] v);
    return ~v + W2'(1);
  endfunction

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Datapath: operand magnitudes, one iteration step, and final sign fixup
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    mag_a     = mag(a, signed_op);
    mag_b     = mag(b, signed_op);

    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Remainder in the upper half, dividend/quotient bits shift through the lower half
    rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    rem_sub  = rem_sh - {1'b0, opnd_q};
    q_bit    = (rem_sh >= {1'b0, opnd_q});
    div_step = {(q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], q_bit};

    prod = neg_q ? neg_w2(acc_q) : acc_q;
    if (!is_div_q) begin
      fin_hi = prod[W2-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else if (dz_q) begin
      fin_hi = a_orig_q;
      fin_lo = {WIDTH{1'b1}};
    end else begin
      fin_hi = rem_neg_q ? neg_w(acc_q[W2-1:WIDTH]) : acc_q[W2-1:WIDTH];
      fin_lo = neg_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_orig_d  = a_orig_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d   = RUN;
              cnt_d     = '0;
              is_div_d  = op[1];
              acc_d     = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
              opnd_d    = op[1] ? mag_b : mag_a;
              neg_d     = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
              rem_neg_d = signed_op && a[WIDTH-1];
              dz_d      = op[1] && (b == '0);
              a_orig_d  = a;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = is_div_q ? div_step : mul_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = FIN;
            cnt_d   = '0;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (!abort) begin
          hi_d   = fin_hi;
          lo_d   = fin_lo;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Iteration operands are only meaningful while RUN/FIN, so they carry no reset
  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    opnd_q    <= opnd_d;
    a_orig_q  <= a_orig_d;
    is_div_q  <= is_div_d;
    neg_q     <= neg_d;
    rem_neg_q <= rem_neg_d;
    dz_q      <= dz_d;
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit at WIDTH=32 and WIDTH=8.
// Expected HI/LO come from a plain-arithmetic model of the MIPS semantics.
module tb_mips_muldiv_unit;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start, abort, sel;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        start32, start8;
  logic        busy32, done32, busy8, done8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;
  logic        busy_m, done_m;
  logic [31:0] hi_m, lo_m;

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t exp_q[$];
  logic [31:0] mhi, mlo;

  always #5 clk = ~clk;

  assign start32 = start & ~sel;
  assign start8  = start & sel;
  assign busy_m  = sel ? busy8 : busy32;
  assign done_m  = sel ? done8 : done32;
  assign hi_m    = sel ? {24'h0, hi8} : hi32;
  assign lo_m    = sel ? {24'h0, lo8} : lo32;

  mips_muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_b(rst_b), .start(start32), .op(op), .a(a), .b(b),
    .abort(abort), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  mips_muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_b(rst_b), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
    .abort(abort), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  function automatic int wid();
    return sel ? 8 : 32;
  endfunction

  function automatic logic [31:0] wmask();
    return sel ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  function automatic res_t ref_op(int w, logic [2:0] o, logic [31:0] x, logic [31:0] y);
    longint mask, ux, uy, sx, sy, q, rm;
    logic [63:0] p;
    res_t r;
    mask = (longint'(1) << w) - 1;
    ux = longint'(x) & mask;
    uy = longint'(y) & mask;
    sx = ux[w-1] ? ux - (longint'(1) << w) : ux;
    sy = uy[w-1] ? uy - (longint'(1) << w) : uy;
    r = '0;
    p = '0;
    q = 0;
    rm = 0;
    case (o)
      3'd0: p = 64'(sx * sy);
      3'd1: p = 64'(ux * uy);
      3'd2, 3'd3: begin
        if (uy == 0) begin
          r.hi = 32'(ux);
          r.lo = 32'(mask);
        end else begin
          if (o == 3'd2) begin
            q = sx / sy;
            rm = sx % sy;
          end else begin
            q = ux / uy;
            rm = ux % uy;
          end
          r.lo = 32'(q & mask);
          r.hi = 32'(rm & mask);
        end
      end
      default: ;
    endcase
    if (o <= 3'd1) begin
      r.hi = 32'((p >> w) & 64'(mask));
      r.lo = 32'(p & 64'(mask));
    end
    return r;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] m;
    m = wmask();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return m;
      3: return (m >> 1) + 32'd1;
      4: return m >> 1;
      default: return $urandom & m;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records what a start of (o,x,y) should do to the architectural state
  task automatic expect_op(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    res_t r;
    if (o <= 3'd3) begin
      r = ref_op(wid(), o, x, y);
      exp_q.push_back(r);
      mhi = r.hi;
      mlo = r.lo;
    end else if (o == 3'd4) begin
      mhi = x & wmask();
    end else if (o == 3'd5) begin
      mlo = x & wmask();
    end
  endtask

  task automatic issue(logic [2:0] o, logic [31:0] x, logic [31:0] y, bit push);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    if (push) expect_op(o, x, y);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    int guard;
    cycles = 0;
    guard = 0;
    @(negedge clk);
    while (busy_m === 1'b1 && guard < 200) begin
      cycles++;
      guard++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(logic [2:0] o, logic [31:0] x, logic [31:0] y, string name);
    int c;
    issue(o, x, y, 1'b1);
    if (o <= 3'd3) begin
      wait_done(c);
      chk({name, "_busy_cycles"}, 32'(c), 32'(wid() + 1));
    end else begin
      @(negedge clk);
      chk({name, "_busy"}, {31'b0, busy_m}, 32'd0);
    end
    chk({name, "_hi"}, hi_m, mhi);
    chk({name, "_lo"}, lo_m, mlo);
    tick();
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    res_t e;
    if (rst_b === 1'b1 && done_m === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_unexpected: got done=1 hi=0x%0h lo=0x%0h, expected no done", hi_m, lo_m);
      end else begin
        e = exp_q.pop_front();
        chk("sb_hi", hi_m, e.hi);
        chk("sb_lo", lo_m, e.lo);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    start = 1'b0; abort = 1'b0; sel = 1'b0; op = '0; a = '0; b = '0;
    mhi = '0; mlo = '0;
    rst_b = 1'b0;
    repeat (3) tick();
    chk("rst_hi", hi32, 32'd0);
    chk("rst_lo", lo32, 32'd0);
    chk("rst_busy", {31'b0, busy32}, 32'd0);
    chk("rst_done", {31'b0, done32}, 32'd0);
    chk("rst_hi8", {24'h0, hi8}, 32'd0);
    rst_b = 1'b1;
    tick();

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    chk("multu_max_hi_k", hi32, 32'hFFFF_FFFE);
    chk("multu_max_lo_k", lo32, 32'h0000_0001);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, "mult_neg");
    chk("mult_neg_hi_k", hi32, 32'hFFFF_FFFF);
    chk("mult_neg_lo_k", lo32, 32'hFFFF_FFF1);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_minsq");
    chk("mult_minsq_hi_k", hi32, 32'h4000_0000);
    chk("mult_minsq_lo_k", lo32, 32'h0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    chk("div_neg_hi_k", hi32, 32'hFFFF_FFFF);
    chk("div_neg_lo_k", lo32, 32'hFFFF_FFFD);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf_hi_k", hi32, 32'h0);
    chk("div_ovf_lo_k", lo32, 32'h8000_0000);
    run_op(3'd3, 32'd7, 32'd0, "divu_z");
    chk("divu_z_hi_k", hi32, 32'd7);
    chk("divu_z_lo_k", lo32, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFF0, 32'd0, "div_z_neg");

    run_op(3'd4, 32'h1234, 32'd0, "mthi");
    chk("mthi_k", hi32, 32'h1234);

    // MTLO arriving mid-RUN must be ignored
    issue(3'd1, 32'd2, 32'd3, 1'b1);
    repeat (4) tick();
    op = 3'd5; a = 32'h55; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(c);
    chk("mtlo_run_busy", 32'(c), 32'(wid() + 1 - 5));
    chk("mtlo_run_hi", hi32, 32'd0);
    chk("mtlo_run_lo", lo32, 32'd6);
    tick();

    // Abort in cycle 10 of RUN
    run_op(3'd4, 32'hAA, 32'd0, "set_hi");
    run_op(3'd5, 32'hBB, 32'd0, "set_lo");
    issue(3'd1, 32'd2, 32'd3, 1'b0);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy32}, 32'd0);
    repeat (40) tick();
    chk("abort_hi", hi32, 32'hAA);
    chk("abort_lo", lo32, 32'hBB);

    // start with abort high in IDLE is dropped; reserved ops are ignored
    abort = 1'b1;
    issue(3'd0, 32'd5, 32'd5, 1'b0);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle_busy", {31'b0, busy32}, 32'd0);
    tick();
    run_op(3'd6, 32'h77, 32'd1, "op6");
    run_op(3'd7, 32'h77, 32'd1, "op7");

    // Back-to-back: second start presented in the done cycle
    issue(3'd3, 32'd100, 32'd7, 1'b1);
    wait_done(c);
    chk("b2b_first_busy", 32'(c), 32'd33);
    op = 3'd0; a = 32'hFFFF_FF00; b = 32'd3; start = 1'b1;
    expect_op(3'd0, 32'hFFFF_FF00, 32'd3);
    tick();
    start = 1'b0;
    wait_done(c);
    chk("b2b_second_busy", 32'(c), 32'd33);
    chk("b2b_hi", hi32, mhi);
    chk("b2b_lo", lo32, mlo);
    tick();

    // Asynchronous reset mid-RUN
    run_op(3'd4, 32'h99, 32'd0, "pre_rst");
    issue(3'd1, 32'h1234, 32'h5678, 1'b0);
    repeat (5) tick();
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("rst_run_hi", hi32, 32'd0);
    chk("rst_run_lo", lo32, 32'd0);
    chk("rst_run_busy", {31'b0, busy32}, 32'd0);
    chk("rst_run_done", {31'b0, done32}, 32'd0);
    mhi = '0;
    mlo = '0;
    tick();
    rst_b = 1'b1;
    tick();

    for (int i = 0; i < 25; i++) run_op(3'($urandom_range(0, 7)), pick(), pick(), "rand32");

    // Narrow instance
    sel = 1'b1;
    mhi = '0;
    mlo = '0;
    tick();
    run_op(3'd1, 32'hFF, 32'hFF, "multu8");
    chk("multu8_hi_k", hi_m, 32'hFE);
    chk("multu8_lo_k", lo_m, 32'h01);
    run_op(3'd2, 32'h80, 32'hFF, "div8_ovf");
    for (int i = 0; i < 20; i++) run_op(3'($urandom_range(0, 7)), pick(), pick(), "rand8");

    repeat (3) tick();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: got %0d pending results, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
